sap_ram: RTL and testbench

//   Main memory stage directly downstream of the memory data register (MDR).
//   The MAR supplies the address. The MDR supplies write data and loads read data.

---
 rtl/sap_ram.sv | 121 ++++++++++++
 tb/tb_sap_ram.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sap_ram.sv
// Byte-wide main memory behind the MAR/MDR with active-low request strobes,
// programmable wait states, a one-cycle completion pulse and a write-protected ROM region.
module sap_ram #(
    parameter int                ADDR_W      = 16,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] ROM_TOP     = 'h0800
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    input  logic              nRD,
    input  logic              nWR,
    output logic              busy,
    output logic              rdy,
    output logic              werr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              op_wr_q, op_wr_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;
    logic              werr_q, werr_d;
    logic              mem_we;

    // Contents survive CLR; only the power-up image is zero.
    logic [7:0] mem_q [2**ADDR_W] = '{default: 8'h00};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        rdy_d   = 1'b0;
        werr_d  = 1'b0;
        mem_we  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Write has priority when both strobes are low.
                if (!nWR || !nRD) begin
                    addr_d  = addr;
                    op_wr_d = !nWR;
                    busy_d  = 1'b1;
                    if (!nWR) wdata_d = wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                if (op_wr_q) begin
                    if (addr_q < ROM_TOP) werr_d = 1'b1;
                    else                  mem_we = 1'b1;
                end else begin
                    rdata_d = mem_q[addr_q];
                end
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            werr_q  <= werr_d;
        end
    end

    // Request capture registers carry no reset; they are only read after an accept.
    always_ff @(posedge CLK) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        op_wr_q <= op_wr_d;
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[addr_q] <= wdata_q;
    end

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign rdy   = rdy_q;
    assign werr  = werr_q;

endmodule

// File: tb/tb_sap_ram.sv
// Self-checking bench for sap_ram: directed scenarios plus randomized traffic
// against a flat-array memory model, on a 1-wait-state and a 0-wait-state instance.
module tb_sap_ram;

    localparam int WSA = 1;

    logic        clk = 1'b0;
    logic        CLR = 1'b1;

    logic [15:0] addr_a = '0, addr_b = '0;
    logic [7:0]  wdata_a = '0, wdata_b = '0;
    logic        nRD_a = 1'b1, nWR_a = 1'b1, nRD_b = 1'b1, nWR_b = 1'b1;
    logic [7:0]  rdata_a, rdata_b;
    logic        busy_a, rdy_a, werr_a, busy_b, rdy_b, werr_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [0:65535];
    logic [7:0] exp_rd;

    always #5 clk = ~clk;

    sap_ram #(.ADDR_W(16), .WAIT_STATES(WSA), .ROM_TOP(16'h0800)) dut_a (
        .CLK(clk), .CLR(CLR), .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a),
        .nRD(nRD_a), .nWR(nWR_a), .busy(busy_a), .rdy(rdy_a), .werr(werr_a)
    );

    sap_ram #(.ADDR_W(16), .WAIT_STATES(0), .ROM_TOP(16'h0800)) dut_b (
        .CLK(clk), .CLR(CLR), .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b),
        .nRD(nRD_b), .nWR(nWR_b), .busy(busy_b), .rdy(rdy_b), .werr(werr_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // mode: 0 = read, 1 = write, 2 = both strobes low
    task automatic acc(input int mode, input logic [15:0] a, input logic [7:0] d,
                       input bit disturb, input string tag);
        int  cyc;
        bit  got;
        bit  is_wr;
        bit  rom;
        is_wr = (mode != 0);
        rom   = is_wr && (a < 16'h0800);
        @(negedge clk);
        addr_a  = a;
        wdata_a = d;
        nRD_a   = !(mode == 0 || mode == 2);
        nWR_a   = !(mode == 1 || mode == 2);
        @(posedge clk); #1;
        chk({tag, "_busy_accept"}, busy_a, 1);
        nRD_a = 1'b1;
        nWR_a = 1'b1;
        if (disturb) begin
            addr_a  = 16'h2000;
            wdata_a = 8'hEE;
            nWR_a   = 1'b0;
        end
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (disturb && cyc == 1) nWR_a = 1'b1;
            if (rdy_a) got = 1;
            else chk({tag, "_busy_wait"}, busy_a, 1);
        end
        if (is_wr && !rom) mdl[a] = d;
        if (!is_wr) exp_rd = mdl[a];
        chk({tag, "_latency"}, cyc, WSA + 1);
        chk({tag, "_busy_done"}, busy_a, 0);
        chk({tag, "_werr"}, werr_a, rom);
        chk({tag, "_rdata"}, rdata_a, exp_rd);
        @(posedge clk); #1;
        chk({tag, "_rdy_one"}, rdy_a, 0);
        chk({tag, "_werr_one"}, werr_a, 0);
    endtask

    initial begin
        logic [15:0] ra;
        for (int i = 0; i < 65536; i++) mdl[i] = 8'h00;
        exp_rd = 8'h00;

        #3;
        chk("rst_busy", busy_a, 0);
        chk("rst_rdy", rdy_a, 0);
        chk("rst_werr", werr_a, 0);
        chk("rst_rdata", rdata_a, 0);
        chk("rst_busy_b", busy_b, 0);
        @(posedge clk);
        @(negedge clk);
        CLR = 1'b0;

        acc(1, 16'h1234, 8'hA5, 0, "t1_wr");
        acc(0, 16'h1234, 8'h00, 0, "t1_rd");
        acc(1, 16'h0010, 8'h55, 0, "t2_romwr");
        acc(0, 16'h0010, 8'h00, 0, "t2_romrd");
        acc(0, 16'h1234, 8'h00, 1, "t3_busyign");
        acc(2, 16'h3000, 8'h3C, 0, "t4_both");
        acc(0, 16'h3000, 8'h00, 0, "t4_rd");
        acc(0, 16'h2000, 8'h00, 0, "t3_rd2000");
        acc(0, 16'h1234, 8'h00, 0, "t5_pre");

        // Abort a write in its wait state with an asynchronous clear.
        @(negedge clk);
        addr_a  = 16'h1234;
        wdata_a = 8'hFF;
        nWR_a   = 1'b0;
        @(posedge clk); #1;
        chk("t5_busy_accept", busy_a, 1);
        nWR_a = 1'b1;
        #2 CLR = 1'b1;
        #1;
        chk("t5_clr_busy", busy_a, 0);
        chk("t5_clr_rdy", rdy_a, 0);
        chk("t5_clr_rdata", rdata_a, 0);
        @(negedge clk);
        CLR    = 1'b0;
        exp_rd = 8'h00;
        acc(0, 16'h1234, 8'h00, 0, "t5_rd");

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 16'($urandom_range(0, 16'h07FF));
                1:       ra = 16'($urandom_range(16'h0800, 16'hFFFF));
                2:       ra = $urandom_range(0, 1) ? 16'h07FF : 16'h0800;
                default: ra = $urandom_range(0, 1) ? 16'h1234 : 16'hFFFF;
            endcase
            acc(int'($urandom_range(0, 2)), ra, 8'($urandom), 0, "rnd");
        end

        // Zero-wait-state instance at the top address.
        @(negedge clk);
        addr_b  = 16'hFFFF;
        wdata_b = 8'h7E;
        nWR_b   = 1'b0;
        @(posedge clk); #1;
        chk("t6_wr_busy", busy_b, 1);
        nWR_b = 1'b1;
        @(posedge clk); #1;
        chk("t6_wr_rdy", rdy_b, 1);
        chk("t6_wr_werr", werr_b, 0);
        chk("t6_wr_busy_done", busy_b, 0);
        @(negedge clk);
        nRD_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("t6_hold_busy", busy_b, (i % 2 == 0));
            chk("t6_hold_rdy", rdy_b, (i % 2 == 1));
            if (i % 2 == 1) chk("t6_hold_rdata", rdata_b, 8'h7E);
        end
        nRD_b = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
